// File: rtl/cam_rw.sv
`default_nettype none
// ============================================================================
// Module   : cam_rw
// Brief    : Writable CAM with per-entry valid bits, registered priority search,
//            multi-hit flag and occupancy status. Optional masked search is
//            enabled by defining CAM_RW_SEARCH_MASK_EN.
// Revision : 1.0
// ============================================================================
module cam_rw #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_all,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  inv_en,
    input  logic [ADDR_WIDTH-1:0] inv_addr,
    input  logic                  search_en,
    input  logic [DATA_WIDTH-1:0] search_key,
`ifdef CAM_RW_SEARCH_MASK_EN
    input  logic [DATA_WIDTH-1:0] search_mask,
`endif
    output logic                  search_done,
    output logic                  search_hit,
    output logic [ADDR_WIDTH-1:0] search_addr,
    output logic                  search_multi,
    output logic [ADDR_WIDTH-1:0] free_addr,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_full;
    logic [ADDR_WIDTH-1:0] r_free_addr;
    logic                  r_done;
    logic                  r_hit;
    logic [ADDR_WIDTH-1:0] r_hit_addr;
    logic                  r_multi;

    logic [DATA_WIDTH-1:0] w_mask;
    logic [DEPTH-1:0]      w_match;
    logic [DEPTH-1:0]      w_wr_sel;
    logic [DEPTH-1:0]      w_inv_sel;
    logic [DEPTH-1:0]      w_valid_next;
    logic                  w_inc;
    logic                  w_dec;
    logic [ADDR_WIDTH:0]   w_count_next;
    logic                  w_hit;
    logic                  w_multi;
    logic [ADDR_WIDTH-1:0] w_hit_addr;
    logic                  w_free_found;
    logic [ADDR_WIDTH-1:0] w_free_addr;

`ifdef CAM_RW_SEARCH_MASK_EN
    assign w_mask = search_mask;
`else
    assign w_mask = '1;
`endif

    // Address decode per entry; indices >= DEPTH match no entry and are ignored.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign w_match[gi]   = r_valid[gi] && (((r_data[gi] ^ search_key) & w_mask) == '0);
            assign w_wr_sel[gi]  = wr_en  && (wr_addr  == ADDR_WIDTH'(gi));
            assign w_inv_sel[gi] = inv_en && (inv_addr == ADDR_WIDTH'(gi));

            always_ff @(posedge clk) begin
                if (!reset && !clear_all && w_wr_sel[gi]) begin
                    r_data[gi] <= wr_data;
                end
            end
        end
    endgenerate

    // Write wins over invalidate on the same entry.
    assign w_valid_next = clear_all ? '0 : ((r_valid & ~w_inv_sel) | w_wr_sel);
    assign w_inc        = |(w_wr_sel & ~r_valid);
    assign w_dec        = |(w_inv_sel & r_valid & ~w_wr_sel);
    assign w_count_next = clear_all ? '0
                        : (r_count + {{ADDR_WIDTH{1'b0}}, w_inc} - {{ADDR_WIDTH{1'b0}}, w_dec});

    always_comb begin
        w_hit        = 1'b0;
        w_multi      = 1'b0;
        w_hit_addr   = '0;
        w_free_found = 1'b0;
        w_free_addr  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_match[i]) begin
                if (w_hit) begin
                    w_multi = 1'b1;
                end else begin
                    w_hit      = 1'b1;
                    w_hit_addr = ADDR_WIDTH'(i);
                end
            end
            if (!w_valid_next[i] && !w_free_found) begin
                w_free_found = 1'b1;
                w_free_addr  = ADDR_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_free_addr <= '0;
        end else begin
            r_valid     <= w_valid_next;
            r_count     <= w_count_next;
            r_full      <= (w_count_next == c_DEPTH);
            r_free_addr <= w_free_addr;
        end
    end

    // Search sees pre-edge contents; results hold while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done     <= 1'b0;
            r_hit      <= 1'b0;
            r_hit_addr <= '0;
            r_multi    <= 1'b0;
        end else if (search_en) begin
            r_done     <= 1'b1;
            r_hit      <= w_hit;
            r_hit_addr <= w_hit_addr;
            r_multi    <= w_multi;
        end else begin
            r_done     <= 1'b0;
        end
    end

    assign search_done  = r_done;
    assign search_hit   = r_hit;
    assign search_addr  = r_hit_addr;
    assign search_multi = r_multi;
    assign free_addr    = r_free_addr;
    assign full         = r_full;
    assign count        = r_count;

endmodule
`default_nettype wire

// File: tb/tb_cam_rw.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_rw
// Brief    : Self-checking bench for cam_rw: directed vector table, corner
//            sequences and random traffic against an array-based model.
// Revision : 1.0
// ============================================================================
module tb_cam_rw;

    logic        clk = 1'b0;
    logic        reset, clear_all, wr_en, inv_en, search_en;
    logic [3:0]  wr_addr, inv_addr;
    logic [15:0] wr_data, search_key, search_mask;
    logic        search_done, search_hit, search_multi, full;
    logic [3:0]  search_addr, free_addr;
    logic [4:0]  count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cam_rw dut (
        .clk         (clk),
        .reset       (reset),
        .clear_all   (clear_all),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .inv_en      (inv_en),
        .inv_addr    (inv_addr),
        .search_en   (search_en),
        .search_key  (search_key),
`ifdef CAM_RW_SEARCH_MASK_EN
        .search_mask (search_mask),
`endif
        .search_done (search_done),
        .search_hit  (search_hit),
        .search_addr (search_addr),
        .search_multi(search_multi),
        .free_addr   (free_addr),
        .full        (full),
        .count       (count)
    );

    // Reference model: plain arrays of contents plus last search result.
    logic        m_valid [16];
    logic [15:0] m_data  [16];
    logic        m_done, m_hit, m_multi;
    logic [3:0]  m_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic clr, input logic wr, input logic [3:0] wa,
                              input logic [15:0] wd, input logic inv, input logic [3:0] ia,
                              input logic se, input logic [15:0] key, input logic [15:0] mask);
        int n;
        if (rst) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
            m_done = 0; m_hit = 0; m_multi = 0; m_addr = 0;
            return;
        end
        if (se) begin
            n = 0;
            m_addr = 0;
            for (int i = 0; i < 16; i++) begin
                if (m_valid[i] && (((m_data[i] ^ key) & mask) == 16'h0)) begin
                    if (n == 0) m_addr = 4'(i);
                    n++;
                end
            end
            m_done = 1; m_hit = (n > 0); m_multi = (n > 1);
        end else begin
            m_done = 0;
        end
        if (clr) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        end else begin
            if (inv) m_valid[ia] = 1'b0;
            if (wr) begin m_valid[wa] = 1'b1; m_data[wa] = wd; end
        end
    endtask

    task automatic step(input logic rst, input logic clr, input logic wr, input logic [3:0] wa,
                        input logic [15:0] wd, input logic inv, input logic [3:0] ia,
                        input logic se, input logic [15:0] key, input logic [15:0] mask);
        int cnt;
        int fr;
        @(negedge clk);
        reset = rst; clear_all = clr; wr_en = wr; wr_addr = wa; wr_data = wd;
        inv_en = inv; inv_addr = ia; search_en = se; search_key = key; search_mask = mask;
        @(posedge clk);
        model_edge(rst, clr, wr, wa, wd, inv, ia, se, key, mask);
        #1;
        cnt = 0;
        fr  = -1;
        for (int i = 0; i < 16; i++) begin
            if (m_valid[i]) cnt++;
            else if (fr < 0) fr = i;
        end
        if (fr < 0) fr = 0;
        chk("done",  32'(search_done),  32'(m_done));
        chk("hit",   32'(search_hit),   32'(m_hit));
        chk("addr",  32'(search_addr),  32'(m_addr));
        chk("multi", 32'(search_multi), 32'(m_multi));
        chk("count", 32'(count),        32'(cnt));
        chk("full",  32'(full),         32'(cnt == 16));
        chk("free",  32'(free_addr),    32'(fr));
    endtask

    typedef struct {
        logic        clr, wr;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        inv;
        logic [3:0]  ia;
        logic        se;
        logic [15:0] key;
        logic        e_done, e_hit;
        logic [3:0]  e_addr;
        logic        e_multi;
        logic [4:0]  e_count;
        logic [3:0]  e_free;
        logic        e_full;
    } vec_t;

    vec_t tv [12];

    initial begin
        //        clr  wr  wa    wd        inv ia    se  key       done hit addr multi cnt  free full
        tv[0]  = '{1'b0,1'b0,4'd0,16'h0000,1'b0,4'd0,1'b1,16'h1234,1'b1,1'b0,4'd0,1'b0,5'd0,4'd0,1'b0};
        tv[1]  = '{1'b0,1'b1,4'd3,16'hABCD,1'b0,4'd0,1'b0,16'h0000,1'b0,1'b0,4'd0,1'b0,5'd1,4'd0,1'b0};
        tv[2]  = '{1'b0,1'b1,4'd9,16'hABCD,1'b0,4'd0,1'b0,16'h0000,1'b0,1'b0,4'd0,1'b0,5'd2,4'd0,1'b0};
        tv[3]  = '{1'b0,1'b0,4'd0,16'h0000,1'b0,4'd0,1'b1,16'hABCD,1'b1,1'b1,4'd3,1'b1,5'd2,4'd0,1'b0};
        tv[4]  = '{1'b0,1'b1,4'd5,16'h5555,1'b0,4'd0,1'b1,16'h5555,1'b1,1'b0,4'd0,1'b0,5'd3,4'd0,1'b0};
        tv[5]  = '{1'b0,1'b0,4'd0,16'h0000,1'b0,4'd0,1'b1,16'h5555,1'b1,1'b1,4'd5,1'b0,5'd3,4'd0,1'b0};
        tv[6]  = '{1'b0,1'b0,4'd0,16'h0000,1'b1,4'd3,1'b1,16'hABCD,1'b1,1'b1,4'd3,1'b1,5'd2,4'd0,1'b0};
        tv[7]  = '{1'b0,1'b0,4'd0,16'h0000,1'b0,4'd0,1'b1,16'hABCD,1'b1,1'b1,4'd9,1'b0,5'd2,4'd0,1'b0};
        tv[8]  = '{1'b0,1'b1,4'd9,16'h0009,1'b1,4'd9,1'b0,16'h0000,1'b0,1'b1,4'd9,1'b0,5'd2,4'd0,1'b0};
        tv[9]  = '{1'b0,1'b0,4'd0,16'h0000,1'b1,4'd15,1'b1,16'h0009,1'b1,1'b1,4'd9,1'b0,5'd2,4'd0,1'b0};
        tv[10] = '{1'b1,1'b1,4'd2,16'h2222,1'b0,4'd0,1'b0,16'h0000,1'b0,1'b1,4'd9,1'b0,5'd0,4'd0,1'b0};
        tv[11] = '{1'b0,1'b0,4'd0,16'h0000,1'b0,4'd0,1'b1,16'h2222,1'b1,1'b0,4'd0,1'b0,5'd0,4'd0,1'b0};

        for (int i = 0; i < 16; i++) begin m_valid[i] = 1'b0; m_data[i] = 16'h0; end
        m_done = 0; m_hit = 0; m_multi = 0; m_addr = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 16'hFFFF);

        for (int i = 0; i < 12; i++) begin
            step(0, tv[i].clr, tv[i].wr, tv[i].wa, tv[i].wd, tv[i].inv, tv[i].ia,
                 tv[i].se, tv[i].key, 16'hFFFF);
            chk($sformatf("tv%0d_done", i),  32'(search_done),  32'(tv[i].e_done));
            chk($sformatf("tv%0d_hit", i),   32'(search_hit),   32'(tv[i].e_hit));
            chk($sformatf("tv%0d_addr", i),  32'(search_addr),  32'(tv[i].e_addr));
            chk($sformatf("tv%0d_multi", i), 32'(search_multi), 32'(tv[i].e_multi));
            chk($sformatf("tv%0d_count", i), 32'(count),        32'(tv[i].e_count));
            chk($sformatf("tv%0d_free", i),  32'(free_addr),    32'(tv[i].e_free));
            chk($sformatf("tv%0d_full", i),  32'(full),         32'(tv[i].e_full));
        end

        // Fill, invalidate one, then write+invalidate the same slot.
        for (int i = 0; i < 16; i++) step(0, 0, 1, 4'(i), 16'h0100 + 16'(i), 0, 0, 0, 0, 16'hFFFF);
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_full",  32'(full),  32'd1);
        step(0, 0, 0, 0, 0, 1, 4'd7, 0, 0, 16'hFFFF);
        chk("inv7_full",  32'(full),      32'd0);
        chk("inv7_count", 32'(count),     32'd15);
        chk("inv7_free",  32'(free_addr), 32'd7);
        step(0, 0, 1, 4'd7, 16'h0777, 1, 4'd7, 0, 0, 16'hFFFF);
        chk("wi7_count", 32'(count), 32'd16);
        chk("wi7_full",  32'(full),  32'd1);
        step(0, 0, 1, 4'd0, 16'h0777, 0, 0, 1, 16'h0777, 16'hFFFF);
        chk("ovw_count", 32'(count),       32'd16);
        chk("ovw_addr",  32'(search_addr), 32'd7);
        step(0, 0, 0, 0, 0, 0, 0, 1, 16'h0777, 16'hFFFF);
        chk("ovw_multi", 32'(search_multi), 32'd1);
        chk("ovw_addr2", 32'(search_addr),  32'd0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 16'h0777, 16'hFFFF);
        chk("rst_done",  32'(search_done), 32'd0);
        chk("rst_count", 32'(count),       32'd0);

`ifdef CAM_RW_SEARCH_MASK_EN
        step(0, 0, 1, 4'd0, 16'h12F0, 0, 0, 0, 0, 16'hFFFF);
        step(0, 0, 0, 0, 0, 0, 0, 1, 16'h1200, 16'hFF00);
        chk("mask_hit",  32'(search_hit),  32'd1);
        chk("mask_addr", 32'(search_addr), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 16'h1200, 16'hFFFF);
        chk("nomask_hit", 32'(search_hit), 32'd0);
`endif

        for (int n = 0; n < 600; n++) begin
            logic [15:0] pool [4];
            logic [15:0] mk;
            pool[0] = 16'h0000; pool[1] = 16'hABCD; pool[2] = 16'h1234; pool[3] = 16'hABC0;
`ifdef CAM_RW_SEARCH_MASK_EN
            mk = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'hFFF0;
`else
            mk = 16'hFFFF;
`endif
            step($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), pool[$urandom_range(0, 3)],
                 $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0, pool[$urandom_range(0, 3)], mk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
